// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost exit/console monitor.
// Used by tohost_monitor and the SoC wrapper's tohost address decode.
package tohost_pkg;

    localparam int unsigned TOHOST_DATA_W = 32;
    localparam int unsigned EXIT_CODE_W   = 31;
    localparam int unsigned CHAR_W        = 8;

    localparam logic [31:0] TOHOST_ADDR     = 32'h8000_1000;
    localparam logic [7:0]  TOHOST_CHAR_TAG = 8'h01;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } tohost_state_e;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_EXIT = 2'd1,
        EV_CHAR = 2'd2
    } tohost_kind_e;

    typedef struct packed {
        tohost_kind_e           kind;
        logic [EXIT_CODE_W-1:0] code;
        logic [CHAR_W-1:0]      ch;
    } tohost_ev_t;

    // Exit (bit 0 set) takes priority over the console tag.
    function automatic tohost_ev_t tohost_decode(input logic [TOHOST_DATA_W-1:0] data);
        tohost_ev_t ev;
        ev.code = data[31:1];
        ev.ch   = data[7:0];
        if (data[0]) begin
            ev.kind = EV_EXIT;
        end else if (data[31:24] == TOHOST_CHAR_TAG) begin
            ev.kind = EV_CHAR;
        end else begin
            ev.kind = EV_NONE;
        end
        return ev;
    endfunction

endpackage

// File: rtl/tohost_char_fifo.sv
// Show-ahead synchronous FIFO with a registered head entry (o_valid/o_data).
// DEPTH must be a power of two and at least 2.
module tohost_char_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = r_valid & i_ready;
    assign w_push_ok = i_push & (~w_full | w_pop);

    // Next head: bypass the write data when it lands in the slot becoming the head.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        w_data_nxt = r_mem[w_rd_ptr_nxt];
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_data_nxt = i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_data   <= w_data_nxt;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_full_c = w_full;

endmodule

// File: rtl/tohost_monitor.sv
// Decodes tohost writes into test exit / console characters, with a watchdog.
// Define TOHOST_TRACE_EN for simulation-only event tracing.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 32'd1_000_000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     tohost_int_i,
    input  logic [TOHOST_DATA_W-1:0] tohost_data_i,
    output logic                     char_valid_o,
    output logic [CHAR_W-1:0]        char_data_o,
    input  logic                     char_ready_i,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic [EXIT_CODE_W-1:0]   exit_code_o,
    output logic                     timeout_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         cycle_cnt_o
);

    localparam bit               WDOG_EN   = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

    logic                     r_prev_int;
    logic [TOHOST_DATA_W-1:0] r_prev_data;
    logic                     w_event;
    tohost_ev_t               w_ev;
    logic                     w_exit;
    logic                     w_char;
    logic                     w_wdog_hit;
    logic                     w_fifo_full;
    logic                     w_pop;
    logic                     w_drop;

    tohost_state_e            r_state;
    tohost_state_e            w_state_nxt;

    logic                     r_done, r_pass, r_fail, r_timeout, r_overflow;
    logic                     w_done_nxt, w_pass_nxt, w_fail_nxt, w_timeout_nxt, w_overflow_nxt;
    logic [EXIT_CODE_W-1:0]   r_exit_code;
    logic [EXIT_CODE_W-1:0]   w_code_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;

    // A held strobe counts once unless the data changes underneath it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prev_int  <= 1'b0;
            r_prev_data <= '0;
        end else begin
            r_prev_int  <= tohost_int_i;
            r_prev_data <= tohost_data_i;
        end
    end

    assign w_event    = tohost_int_i & (~r_prev_int | (tohost_data_i != r_prev_data));
    assign w_ev       = tohost_decode(tohost_data_i);
    assign w_exit     = w_event && (w_ev.kind == EV_EXIT);
    assign w_char     = w_event && (w_ev.kind == EV_CHAR);
    assign w_wdog_hit = WDOG_EN && (r_cnt == WDOG_LAST);
    assign w_pop      = char_valid_o & char_ready_i;
    assign w_drop     = w_char & w_fifo_full & ~w_pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Exit beats a watchdog expiry in the same cycle; terminal states hold.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUN) begin
            if (w_exit) begin
                w_state_nxt = (w_ev.code == '0) ? ST_PASS : ST_FAIL;
            end else if (w_wdog_hit) begin
                w_state_nxt = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        w_done_nxt     = (w_state_nxt != ST_RUN);
        w_pass_nxt     = (w_state_nxt == ST_PASS);
        w_fail_nxt     = (w_state_nxt == ST_FAIL) || (w_state_nxt == ST_TIMEOUT);
        w_timeout_nxt  = (w_state_nxt == ST_TIMEOUT);
        w_overflow_nxt = r_overflow | w_drop;
        w_code_nxt     = r_exit_code;
        w_cnt_nxt      = r_cnt;
        if ((r_state == ST_RUN) && w_exit) begin
            w_code_nxt = w_ev.code;
        end
        if ((w_state_nxt == ST_RUN) && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_exit_code <= '0;
            r_cnt       <= '0;
        end else begin
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_timeout   <= w_timeout_nxt;
            r_overflow  <= w_overflow_nxt;
            r_exit_code <= w_code_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    tohost_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W)
    ) u_char_fifo (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_push   (w_char),
        .i_wdata  (w_ev.ch),
        .i_ready  (char_ready_i),
        .o_valid  (char_valid_o),
        .o_data   (char_data_o),
        .o_full_c (w_fifo_full)
    );

    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign timeout_o   = r_timeout;
    assign overflow_o  = r_overflow;
    assign exit_code_o = r_exit_code;
    assign cycle_cnt_o = r_cnt;

`ifdef TOHOST_TRACE_EN
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (w_exit) begin
                $display("[tohost] cycle %0d EXIT code %0d", r_cnt, w_ev.code);
            end
            if (w_char) begin
                $display("[tohost] cycle %0d CHAR 0x%02h", r_cnt, w_ev.ch);
            end
            if (w_drop) begin
                $display("[tohost] cycle %0d DROP 0x%02h", r_cnt, w_ev.ch);
            end
            if ((r_state == ST_RUN) && (w_state_nxt != ST_RUN)) begin
                $display("[tohost] cycle %0d enter %s", r_cnt, w_state_nxt.name());
            end
            if (w_pop) begin
                $write("%c", char_data_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor (MAX_CYCLES=100, FIFO_DEPTH=4).
module tb_tohost_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tohost_int = 1'b0;
    logic [31:0] tohost_data = '0;
    logic        char_ready = 1'b0;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        done, pass, fail, timeout, overflow;
    logic [30:0] exit_code;
    logic [31:0] cycle_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tohost_monitor #(
        .MAX_CYCLES (100),
        .FIFO_DEPTH (4),
        .CNT_W      (32)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .tohost_int_i  (tohost_int),
        .tohost_data_i (tohost_data),
        .char_valid_o  (char_valid),
        .char_data_o   (char_data),
        .char_ready_i  (char_ready),
        .done_o        (done),
        .pass_o        (pass),
        .fail_o        (fail),
        .exit_code_o   (exit_code),
        .timeout_o     (timeout),
        .overflow_o    (overflow),
        .cycle_cnt_o   (cycle_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        tohost_int  = v;
        tohost_data = d;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(1'b0, 32'h0);
        char_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ch;

        // Reset state
        reset_dut();
        check("rst_done", 64'(done), 64'h0);
        check("rst_pass", 64'(pass), 64'h0);
        check("rst_fail", 64'(fail), 64'h0);
        check("rst_timeout", 64'(timeout), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_exit_code", 64'(exit_code), 64'h0);
        check("rst_valid", 64'(char_valid), 64'h0);
        check("rst_cnt", 64'(cycle_cnt), 64'h0);

        // Exit code 0 -> PASS, counter frozen
        repeat (5) tick();
        check("cnt_running", 64'(cycle_cnt), 64'd5);
        drive(1'b1, 32'h1);
        tick();
        drive(1'b0, 32'h0);
        check("pass_done", 64'(done), 64'h1);
        check("pass_pass", 64'(pass), 64'h1);
        check("pass_fail", 64'(fail), 64'h0);
        check("pass_code", 64'(exit_code), 64'h0);
        check("pass_cnt", 64'(cycle_cnt), 64'd5);
        repeat (3) tick();
        check("pass_cnt_frozen", 64'(cycle_cnt), 64'd5);

        // Held strobe, nonzero code -> FAIL, later exit ignored
        reset_dut();
        drive(1'b1, 32'h0000_0007);
        repeat (3) tick();
        drive(1'b0, 32'h0);
        check("fail_fail", 64'(fail), 64'h1);
        check("fail_done", 64'(done), 64'h1);
        check("fail_code", 64'(exit_code), 64'h3);
        tick();
        drive(1'b1, 32'h1);
        tick();
        drive(1'b0, 32'h0);
        tick();
        check("fail_late_pass", 64'(pass), 64'h0);
        check("fail_late_code", 64'(exit_code), 64'h3);

        // Console chars streamed with ready high
        reset_dut();
        char_ready = 1'b1;
        drive(1'b1, 32'h0100_0048);
        tick();
        check("chr0_valid", 64'(char_valid), 64'h1);
        check("chr0_data", 64'(char_data), 64'h48);
        drive(1'b1, 32'h0100_0042);
        tick();
        check("chr1_data", 64'(char_data), 64'h42);
        drive(1'b1, 32'h0100_000A);
        tick();
        check("chr2_data", 64'(char_data), 64'h0A);
        drive(1'b0, 32'h0);
        tick();
        check("chr_drained", 64'(char_valid), 64'h0);
        check("chr_no_overflow", 64'(overflow), 64'h0);

        // Held char strobe enqueues once
        char_ready = 1'b0;
        drive(1'b1, 32'h0100_005A);
        repeat (3) tick();
        drive(1'b0, 32'h0);
        tick();
        check("held_valid", 64'(char_valid), 64'h1);
        check("held_data", 64'(char_data), 64'h5A);
        char_ready = 1'b1;
        tick();
        check("held_single", 64'(char_valid), 64'h0);

        // Untagged write ignored
        drive(1'b1, 32'h0200_0010);
        tick();
        drive(1'b0, 32'h0);
        tick();
        check("ign_valid", 64'(char_valid), 64'h0);
        check("ign_done", 64'(done), 64'h0);

        // Bit 0 set beats the char tag
        drive(1'b1, 32'h0100_004F);
        tick();
        drive(1'b0, 32'h0);
        check("prio_fail", 64'(fail), 64'h1);
        check("prio_code", 64'(exit_code), 64'h0080_0027);
        tick();
        check("prio_no_char", 64'(char_valid), 64'h0);

        // Late char in terminal state still printed
        drive(1'b1, 32'h0100_0030);
        tick();
        drive(1'b0, 32'h0);
        check("late_valid", 64'(char_valid), 64'h1);
        check("late_data", 64'(char_data), 64'h30);
        check("late_code", 64'(exit_code), 64'h0080_0027);

        // Push + pop while full: no drop
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0100_0010 + 32'(2 * i));
            tick();
        end
        char_ready = 1'b1;
        drive(1'b1, 32'h0100_001A);
        tick();
        drive(1'b0, 32'h0);
        check("pp_overflow", 64'(overflow), 64'h0);
        check("pp_head0", 64'(char_data), 64'h12);
        tick();
        check("pp_head1", 64'(char_data), 64'h14);
        tick();
        check("pp_head2", 64'(char_data), 64'h16);
        tick();
        check("pp_head3", 64'(char_data), 64'h1A);
        tick();
        check("pp_empty", 64'(char_valid), 64'h0);

        // Overflow: 5 pushes into depth 4
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0100_0020 + 32'(2 * i));
            tick();
        end
        drive(1'b0, 32'h0);
        check("ovf_flag", 64'(overflow), 64'h1);
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch = 8'(8'h20 + 2 * i);
            check("ovf_pop_valid", 64'(char_valid), 64'h1);
            check("ovf_pop_data", 64'(char_data), 64'(ch));
            tick();
        end
        check("ovf_empty", 64'(char_valid), 64'h0);
        check("ovf_sticky", 64'(overflow), 64'h1);

        // Watchdog expiry
        reset_dut();
        repeat (99) tick();
        check("wd_cnt99", 64'(cycle_cnt), 64'd99);
        check("wd_not_yet", 64'(timeout), 64'h0);
        tick();
        check("wd_timeout", 64'(timeout), 64'h1);
        check("wd_fail", 64'(fail), 64'h1);
        check("wd_done", 64'(done), 64'h1);
        check("wd_pass", 64'(pass), 64'h0);
        check("wd_code", 64'(exit_code), 64'h0);
        check("wd_cnt", 64'(cycle_cnt), 64'd99);
        repeat (3) tick();
        check("wd_cnt_frozen", 64'(cycle_cnt), 64'd99);

        // Exit in the watchdog cycle wins
        reset_dut();
        repeat (99) tick();
        drive(1'b1, 32'h1);
        tick();
        drive(1'b0, 32'h0);
        check("wdx_pass", 64'(pass), 64'h1);
        check("wdx_timeout", 64'(timeout), 64'h0);
        check("wdx_cnt", 64'(cycle_cnt), 64'd99);
        tick();
        check("wdx_timeout_late", 64'(timeout), 64'h0);

        // Asynchronous reset mid-stream
        reset_dut();
        drive(1'b1, 32'h0100_0044);
        tick();
        drive(1'b1, 32'h0100_0046);
        tick();
        drive(1'b1, 32'h0000_0003);
        tick();
        drive(1'b0, 32'h0);
        check("ar_pre_fail", 64'(fail), 64'h1);
        check("ar_pre_valid", 64'(char_valid), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_done", 64'(done), 64'h0);
        check("ar_fail", 64'(fail), 64'h0);
        check("ar_code", 64'(exit_code), 64'h0);
        check("ar_valid", 64'(char_valid), 64'h0);
        check("ar_cnt", 64'(cycle_cnt), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_fifo_empty", 64'(char_valid), 64'h0);
        drive(1'b1, 32'h0100_0048);
        tick();
        drive(1'b0, 32'h0);
        check("ar_new_head", 64'(char_data), 64'h48);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
